// File: rtl/crc_block_ctrl.sv
// Block sequencer for the copy-DMA CRC datapath: captures one multi-word block,
// folds it into a running CRC-32 (MPEG-2 form) one word per cycle, reports done.
module crc_block_ctrl #(
    parameter int unsigned NUM_WORDS = 8,
    parameter logic [31:0]  CRC_POLY  = 32'h04C11DB7,
    parameter logic [31:0]  CRC_INIT  = 32'hFFFFFFFF
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             start_i,
    input  logic                             first_i,
    input  logic                             last_i,
    input  logic [$clog2(NUM_WORDS+1)-1:0]   word_cnt_i,
    input  logic [NUM_WORDS*32-1:0]          data_i,
    input  logic                             abort_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [31:0]                      crc_o,
    output logic                             crc_valid_o
);

    localparam int unsigned CNT_W  = $clog2(NUM_WORDS + 1);
    localparam int unsigned IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [WORD_W-1:0]   buf_q [NUM_WORDS];
    logic [IDX_W-1:0]    idx_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                last_q;

    logic [CNT_W-1:0]    cnt_sat_c;
    logic [WORD_W-1:0]   crc_next_c;
    logic                last_word_c;

    // One full 32-bit word folded into the CRC in a single combinational step.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c ^ d;
        for (int unsigned i = 0; i < 32; i++) begin
            r = r[31] ? ((r << 1) ^ CRC_POLY) : (r << 1);
        end
        return r;
    endfunction

    assign cnt_sat_c   = (word_cnt_i > CNT_W'(NUM_WORDS)) ? CNT_W'(NUM_WORDS) : word_cnt_i;
    assign crc_next_c  = crc_step(crc_o, buf_q[idx_q]);
    assign last_word_c = (idx_q == IDX_W'(cnt_q - CNT_W'(1)));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            crc_o       <= '0;
            crc_valid_o <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            done_o <= 1'b0;
            // Abort wins over a same-cycle start and over completion.
            if (abort_i) begin
                state_q     <= S_IDLE;
                busy_o      <= 1'b0;
                crc_o       <= CRC_INIT;
                crc_valid_o <= 1'b0;
                idx_q       <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                                buf_q[i] <= data_i[i*WORD_W +: WORD_W];
                            end
                            cnt_q  <= cnt_sat_c;
                            last_q <= last_i;
                            idx_q  <= '0;
                            if (first_i) begin
                                crc_o <= CRC_INIT;
                            end
                            if (cnt_sat_c == '0) begin
                                state_q     <= S_DONE;
                                done_o      <= 1'b1;
                                crc_valid_o <= last_i;
                            end else begin
                                state_q     <= S_RUN;
                                busy_o      <= 1'b1;
                                crc_valid_o <= 1'b0;
                            end
                        end
                    end
                    S_RUN: begin
                        crc_o <= crc_next_c;
                        idx_q <= idx_q + IDX_W'(1);
                        if (last_word_c) begin
                            state_q     <= S_DONE;
                            busy_o      <= 1'b0;
                            done_o      <= 1'b1;
                            crc_valid_o <= last_q;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/crc_block_ctrl.md
Name: crc_block_ctrl

Overview:
Sequencer for the shared CRC datapath of the copy-DMA. It accepts an 8x32-bit block from the DMA data register on a start handshake, feeds the words one per cycle through a CRC-32 update, and accumulates across consecutive blocks of one transfer (first/last flags). It reports busy/done to the DMA FSM, which holds in DMA_COMPUTE until done_o, and presents the final CRC with a sticky valid flag.

Parameters:
NUM_WORDS, 8, words per block; data_i width is NUM_WORDS x 32.
CRC_POLY, 32'h04C11DB7, generator polynomial, non-reflected, MSB-first.
CRC_INIT, 32'hFFFFFFFF, seed loaded on a first block and on abort.

Ports:
clk_i  in  1  clock, rising edge
reset_n_i  in  1  asynchronous active-low reset
start_i  in  1  request to process one block; sampled only in IDLE
first_i  in  1  qualifies start_i: seed running CRC with CRC_INIT before this block
last_i  in  1  qualifies start_i: block ends the transfer
word_cnt_i  in  $clog2(NUM_WORDS+1)  valid words in block, counted from index 0
data_i  in  NUM_WORDS x 32  block words; word 0 processed first
abort_i  in  1  cancel current block/transfer
busy_o  out  1  high from the cycle after an accepted start until done
done_o  out  1  one-cycle pulse per completed block
crc_o  out  32  running/final CRC register
crc_valid_o  out  1  crc_o holds the final CRC of a transfer; sticky

Behaviour:
- Reset (async, reset_n_i low): state IDLE, busy_o=0, done_o=0, crc_o=0, crc_valid_o=0, word buffer and index cleared.
- States: IDLE, RUN, DONE.
- IDLE: start_i=1 and abort_i=0 (cycle T) -> capture data_i, word_cnt_i (values > NUM_WORDS saturate to NUM_WORDS), last_i; crc_o<=CRC_INIT if first_i else unchanged; crc_valid_o<=0; idx<=0; go RUN (busy_o=1 from T+1).
- Zero count: word_cnt_i=0 goes straight to DONE; done_o at T+1; CRC unchanged except a first_i seed.
- RUN: each cycle crc <= step(crc, buf[idx]); idx++. After word cnt-1 go DONE. N words processed in cycles T+1..T+N.
- step(c,d): c ^= d; 32 iterations of c = c[31] ? (c<<1)^CRC_POLY : c<<1. Single combinational word step; no registered inner pipeline.
- DONE (cycle T+N+1): done_o=1, busy_o=0; crc_valid_o<=1 if captured last was set; next state IDLE. Back-to-back start accepted at T+N+2 earliest.
- Captured data is used; data_i changes after T have no effect.
- start_i outside IDLE: ignored, not queued.
- abort_i any state: next cycle IDLE, busy_o=0, no done_o, crc_o<=CRC_INIT, crc_valid_o<=0. Abort beats simultaneous start in IDLE and beats completion in DONE's entry cycle.
- crc_valid_o stays high until next accepted start, abort, or reset.
- No xorout, no reflection: result equals CRC-32/MPEG-2 of block bytes in big-endian word order.
- Reset asserted mid-RUN: immediate return to reset values; no done_o.

Test Plan:
- Reset then first+last start, cnt=8, all words 0, CRC_INIT overridden to 0 -> done_o exactly at T+9, crc_o=32'h00000000, crc_valid_o=1.
- Same, CRC_INIT=0, words 0..6 = 0, word 7 = 32'h00000001 -> crc_o=32'h04C11DB7; busy_o high T+1..T+8.
- Default seed, two blocks (first then last, cnt 8 and 3, random data) -> crc_o matches CRC-32/MPEG-2 golden model over the 11 words; crc_valid_o low after block 1, high after block 2.
- cnt=0 and cnt=15 -> done at T+1 with CRC unchanged; done at T+9 equal to cnt=8 result.
- start_i pulsed during RUN and data_i changed after T -> ignored; single done_o; CRC from captured data.
- abort_i at T+4, plus abort+start together in IDLE -> no done_o, crc_o=32'hFFFFFFFF, crc_valid_o=0, stays IDLE; async reset mid-RUN clears all outputs.
